// File: rtl/pixel_pkg.sv
// Shared types and geometry helpers for the pixel readout path.
// Entry fields are sized for the widest supported sensor; narrower builds zero-extend.
package pixel_pkg;

  localparam int PIX_MAX_DATA_W = 16;
  localparam int PIX_MAX_ADDR_W = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } pixel_state_e;

  typedef struct packed {
    logic [PIX_MAX_DATA_W-1:0] data;
    logic [PIX_MAX_ADDR_W-1:0] row;
    logic [PIX_MAX_ADDR_W-1:0] col;
    logic                      sof;
    logic                      eof;
  } pixel_entry_t;

  // Side length of a square frame: largest integer whose square fits in num_pixels.
  function automatic int pixel_side(input int num_pixels);
    int side;
    side = 0;
    for (int i = 0; i * i <= num_pixels; i++) begin
      side = i;
    end
    return side;
  endfunction

  function automatic int pixel_addr_w(input int num_pixels);
    return $clog2(pixel_side(num_pixels));
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through buffer with wrap-bit pointers; a push into a full
// buffer succeeds only when the head is popped on the same edge.
module pixel_fifo #(
  parameter type entry_t = logic,
  parameter int  DEPTH   = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push_i,
  input  entry_t wdata_i,
  input  logic   pop_i,
  output entry_t rdata_o,
  output logic   valid_o,
  output logic   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [DEPTH];

  logic empty;
  logic full;
  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;
  assign valid_o = !empty;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pixel_readout.sv
// Pixel readout: captures addressed ADC samples during a read window, buffers
// them for a ready/valid consumer, and tracks frame completion and error flags.
module pixel_readout
  import pixel_pkg::*;
#(
  parameter  int NUM_PIXELS = 4,
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 8,
  localparam int ADDR_W     = pixel_addr_w(NUM_PIXELS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read,
  input  logic [ADDR_W-1:0] row_addr,
  input  logic [ADDR_W-1:0] col_addr,
  input  logic [DATA_W-1:0] pixel_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_row,
  output logic [ADDR_W-1:0] out_col,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              short_frame,
  output logic [7:0]        frame_cnt
);

  localparam int                SIDE      = pixel_side(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIDE - 1);
  localparam int                CNT_W     = $clog2(NUM_PIXELS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NUM_PIXELS);

  pixel_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             short_q, short_d;
  logic             ovf_q;

  pixel_entry_t cap_d, cap_q;
  logic         cap_vld_q;

  pixel_entry_t head;
  pixel_entry_t unused_head;
  logic         fifo_valid;
  logic         fifo_drop;

  // Capture stage: one register slice between the sensor bus and the buffer.
  always_comb begin
    cap_d      = '0;
    cap_d.data = PIX_MAX_DATA_W'(pixel_data);
    cap_d.row  = PIX_MAX_ADDR_W'(row_addr);
    cap_d.col  = PIX_MAX_ADDR_W'(col_addr);
    cap_d.sof  = (row_addr == '0) && (col_addr == '0);
    cap_d.eof  = (row_addr == LAST_ADDR) && (col_addr == LAST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_vld_q <= 1'b0;
      cap_q     <= '0;
    end else begin
      cap_vld_q <= read;
      if (read) cap_q <= cap_d;
    end
  end

  // Window tracking: the sample on the entry edge is the first one counted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    short_d     = short_q;
    case (state_q)
      IDLE: begin
        if (read) begin
          state_d = CAPTURE;
          cnt_d   = CNT_W'(1);
        end
      end
      CAPTURE: begin
        if (read) begin
          if (cnt_q <= CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) frame_cnt_d = frame_cnt_q + 8'd1;
          else                   short_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      short_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      short_q     <= short_d;
      ovf_q       <= ovf_q | fifo_drop;
    end
  end

  pixel_fifo #(
    .entry_t (pixel_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (cap_vld_q),
    .wdata_i (cap_q),
    .pop_i   (out_ready),
    .rdata_o (head),
    .valid_o (fifo_valid),
    .drop_o  (fifo_drop)
  );

  // Padding bits of the wide entry are intentionally not brought out.
  assign unused_head = head;

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign out_valid   = fifo_valid;
  assign out_data    = fifo_valid ? head.data[DATA_W-1:0] : '0;
  assign out_row     = fifo_valid ? head.row[ADDR_W-1:0]  : '0;
  assign out_col     = fifo_valid ? head.col[ADDR_W-1:0]  : '0;
  assign out_sof     = fifo_valid && head.sof;
  assign out_eof     = fifo_valid && head.eof;
  assign overflow    = ovf_q;
  assign short_frame = short_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout (4-pixel frames, 2-entry buffer): directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_pixel_readout;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int SIDE  = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       r;
    logic       c;
    logic       s;
    logic       e;
  } ent_t;

  typedef struct {
    ent_t ent;
    int   cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          read;
  logic [0:0]    row_addr;
  logic [0:0]    col_addr;
  logic [DW-1:0] pixel_data;
  logic [DW-1:0] out_data;
  logic [0:0]    out_row;
  logic [0:0]    out_col;
  logic          out_sof;
  logic          out_eof;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
  logic          short_frame;
  logic [7:0]    frame_cnt;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  beat_t beats[$];

  // Reference model state
  ent_t m_q[$];
  logic m_pend_vld;
  ent_t m_pend;
  bit   m_inwin;
  int   m_cnt;
  int   m_frames;
  bit   m_short;
  bit   m_ovf;

  always #5 clk = ~clk;

  pixel_readout #(
    .NUM_PIXELS (NP),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .read        (read),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .pixel_data  (pixel_data),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .short_frame (short_frame),
    .frame_cnt   (frame_cnt)
  );

  task automatic model_edge();
    int   sz;
    bit   popped;
    ent_t tmp;
    if (!reset_n) begin
      m_q.delete();
      m_pend_vld = 1'b0;
      m_pend     = '0;
      m_inwin    = 0;
      m_cnt      = 0;
      m_frames   = 0;
      m_short    = 0;
      m_ovf      = 0;
    end else begin
      sz     = m_q.size();
      popped = 0;
      if (out_ready && sz > 0) begin
        tmp    = m_q.pop_front();
        popped = 1;
      end
      if (m_pend_vld) begin
        if (sz < DEPTH || popped) m_q.push_back(m_pend);
        else                      m_ovf = 1;
      end
      m_pend_vld = read;
      if (read)
        m_pend = {pixel_data, row_addr, col_addr,
                  (row_addr == 1'b0) && (col_addr == 1'b0),
                  (int'(row_addr) == SIDE - 1) && (int'(col_addr) == SIDE - 1)};
      if (read) begin
        if (!m_inwin) begin
          m_inwin = 1;
          m_cnt   = 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else if (m_inwin) begin
        m_inwin = 0;
        if (m_cnt == NP) m_frames = (m_frames + 1) % 256;
        else             m_short  = 1;
      end
    end
  endtask

  // One clock: drive at negedge, log a beat if it will be accepted, advance model.
  task automatic cycle(input logic rd, input logic r, input logic c,
                       input logic [7:0] d, input logic rdy, input logic rn);
    @(negedge clk);
    read       = rd;
    row_addr   = r;
    col_addr   = c;
    pixel_data = d;
    out_ready  = rdy;
    reset_n    = rn;
    if (out_valid === 1'b1 && rdy && rn)
      beats.push_back('{ent: {out_data, out_row, out_col, out_sof, out_eof}, cyc: cyc});
    @(posedge clk);
    model_edge();
    cyc = cyc + 1;
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    compared++;
    if (out_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h expected 00", out_data); end
    compared++;
    if ({out_row, out_col, out_sof, out_eof} !== 4'b0000) begin
      mismatched++; $display("FAIL reset_addr_flags: got %b expected 0000", {out_row, out_col, out_sof, out_eof});
    end
    compared++;
    if ({overflow, short_frame} !== 2'b00) begin
      mismatched++; $display("FAIL reset_sticky: got %b expected 00", {overflow, short_frame});
    end
    compared++;
    if (frame_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
  endtask

  task automatic test_basic_frame();
    int t0;
    beats.delete();
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i >> 1), 1'(i & 1), 8'(17 * (i + 1)), 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    compared++;
    if (beats.size() != 4) begin mismatched++; $display("FAIL basic_count: got %0d beats expected 4", beats.size()); end
    for (int k = 0; k < 4 && k < beats.size(); k++) begin
      compared++;
      if (beats[k].ent !== {8'(17 * (k + 1)), 1'(k >> 1), 1'(k & 1), (k == 0), (k == 3)}) begin
        mismatched++;
        $display("FAIL basic_beat%0d: got %h expected %h", k, beats[k].ent,
                 {8'(17 * (k + 1)), 1'(k >> 1), 1'(k & 1), (k == 0), (k == 3)});
      end
    end
    if (beats.size() > 0) begin
      compared++;
      if (beats[0].cyc != t0 + 2) begin
        mismatched++; $display("FAIL basic_latency: first beat at cycle %0d expected %0d", beats[0].cyc, t0 + 2);
      end
    end
    compared++;
    if (frame_cnt !== 8'd1 || short_frame !== 1'b0 || overflow !== 1'b0) begin
      mismatched++; $display("FAIL basic_status: got cnt=%0d short=%b ovf=%b expected 1 0 0", frame_cnt, short_frame, overflow);
    end
  endtask

  task automatic test_overflow();
    beats.delete();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i >> 1), 1'(i & 1), 8'(17 * (i + 1)), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    compared++;
    if (overflow !== 1'b1 || frame_cnt !== 8'd1) begin
      mismatched++; $display("FAIL ovf_status: got ovf=%b cnt=%0d expected 1 1", overflow, frame_cnt);
    end
    compared++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_sof !== 1'b1) begin
      mismatched++; $display("FAIL ovf_head_hold: got v=%b d=%h sof=%b expected 1 11 1", out_valid, out_data, out_sof);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    compared++;
    if (beats.size() != 2) begin mismatched++; $display("FAIL ovf_count: got %0d beats expected 2", beats.size()); end
    for (int k = 0; k < 2 && k < beats.size(); k++) begin
      compared++;
      if (beats[k].ent.d !== 8'(17 * (k + 1))) begin
        mismatched++; $display("FAIL ovf_beat%0d: got %h expected %h", k, beats[k].ent.d, 8'(17 * (k + 1)));
      end
    end
    compared++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      mismatched++; $display("FAIL ovf_drained: got v=%b ovf=%b expected 0 1", out_valid, overflow);
    end
  endtask

  task automatic test_full_pop();
    beats.delete();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i >> 1), 1'(i & 1), 8'(17 * (i + 1)), (i >= 3), 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL fullpop_ovf: got %b expected 0", overflow); end
    compared++;
    if (beats.size() != 4) begin mismatched++; $display("FAIL fullpop_count: got %0d beats expected 4", beats.size()); end
    for (int k = 0; k < 4 && k < beats.size(); k++) begin
      compared++;
      if (beats[k].ent.d !== 8'(17 * (k + 1))) begin
        mismatched++; $display("FAIL fullpop_beat%0d: got %h expected %h", k, beats[k].ent.d, 8'(17 * (k + 1)));
      end
    end
    compared++;
    if (frame_cnt !== 8'd1) begin mismatched++; $display("FAIL fullpop_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_short_frame();
    beats.delete();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'(i >> 1), 1'(i & 1), 8'(17 * (i + 1)), 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    compared++;
    if (short_frame !== 1'b1 || frame_cnt !== 8'd0) begin
      mismatched++; $display("FAIL short_status: got short=%b cnt=%0d expected 1 0", short_frame, frame_cnt);
    end
    compared++;
    if (beats.size() != 3) begin mismatched++; $display("FAIL short_count: got %0d beats expected 3", beats.size()); end
    if (beats.size() == 3) begin
      compared++;
      if (beats[2].ent !== {8'h33, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        mismatched++; $display("FAIL short_last: got %h expected %h", beats[2].ent, {8'h33, 1'b1, 1'b0, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i >> 1), 1'(i & 1), 8'(17 * (i + 1)), 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h5a, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 8'h6b, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'h7c, 1'b0, 1'b0);
    compared++;
    if ({out_valid, overflow, short_frame} !== 3'b000 || frame_cnt !== 8'd0 || out_data !== 8'h00) begin
      mismatched++;
      $display("FAIL midreset_clear: got v=%b ovf=%b short=%b cnt=%0d d=%h expected all 0",
               out_valid, overflow, short_frame, frame_cnt, out_data);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    compared++;
    if (short_frame !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++; $display("FAIL midreset_no_short: got short=%b v=%b expected 0 0", short_frame, out_valid);
    end
    beats.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i >> 1), 1'(i & 1), 8'(8'hA0 + i), 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    compared++;
    if (beats.size() != 4) begin mismatched++; $display("FAIL midreset_count: got %0d beats expected 4", beats.size()); end
    for (int k = 0; k < 4 && k < beats.size(); k++) begin
      compared++;
      if (beats[k].ent !== {8'(8'hA0 + k), 1'(k >> 1), 1'(k & 1), (k == 0), (k == 3)}) begin
        mismatched++; $display("FAIL midreset_beat%0d: got %h expected %h", k, beats[k].ent,
                               {8'(8'hA0 + k), 1'(k >> 1), 1'(k & 1), (k == 0), (k == 3)});
      end
    end
    compared++;
    if (frame_cnt !== 8'd1 || short_frame !== 1'b0) begin
      mismatched++; $display("FAIL midreset_status: got cnt=%0d short=%b expected 1 0", frame_cnt, short_frame);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i >> 1), 1'(i & 1), 8'(f + i), 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      if (f == 254) begin
        compared++;
        if (frame_cnt !== 8'd255) begin mismatched++; $display("FAIL wrap_255: got %0d expected 255", frame_cnt); end
      end
    end
    compared++;
    if (frame_cnt !== 8'd0 || short_frame !== 1'b0) begin
      mismatched++; $display("FAIL wrap_0: got cnt=%0d short=%b expected 0 0", frame_cnt, short_frame);
    end
  endtask

  task automatic test_random();
    int   wleft;
    int   gap;
    int   idx;
    bit   raster;
    logic rd, r, c, rdy, rn;
    ent_t exp_head;
    wleft = 0;
    gap   = 0;
    idx   = 0;
    raster = 1;
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      r = 1'($urandom);
      c = 1'($urandom);
      if (wleft > 0) begin
        rd = 1'b1;
        if (raster) begin
          r = 1'(idx >> 1);
          c = 1'(idx & 1);
        end
        idx++;
        wleft--;
      end else if (gap > 0) begin
        rd = 1'b0;
        gap--;
      end else begin
        rd     = 1'b0;
        raster = ($urandom_range(0, 3) != 0);
        wleft  = raster ? NP : int'($urandom_range(1, 6));
        gap    = int'($urandom_range(0, 3));
        idx    = 0;
      end
      rdy = ($urandom_range(0, 9) < 6);
      rn  = ($urandom_range(0, 199) != 0);
      cycle(rd, r, c, 8'($urandom), rdy, rn);
      exp_head = (m_q.size() > 0) ? m_q[0] : '0;
      compared++;
      if (out_valid !== (m_q.size() > 0)) begin
        mismatched++; $display("FAIL rand_valid@%0d: got %b expected %b", cyc, out_valid, (m_q.size() > 0));
      end
      compared++;
      if ({out_data, out_row, out_col, out_sof, out_eof} !== exp_head) begin
        mismatched++; $display("FAIL rand_head@%0d: got %h expected %h", cyc,
                               {out_data, out_row, out_col, out_sof, out_eof}, exp_head);
      end
      compared++;
      if (overflow !== m_ovf || short_frame !== m_short || frame_cnt !== 8'(m_frames)) begin
        mismatched++; $display("FAIL rand_status@%0d: got ovf=%b short=%b cnt=%0d expected %b %b %0d", cyc,
                               overflow, short_frame, frame_cnt, m_ovf, m_short, m_frames);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    read       = 1'b0;
    row_addr   = 1'b0;
    col_addr   = 1'b0;
    pixel_data = '0;
    out_ready  = 1'b0;
    m_pend_vld = 1'b0;
    m_pend     = '0;
    m_inwin    = 0;
    m_cnt      = 0;
    m_frames   = 0;
    m_short    = 0;
    m_ovf      = 0;
    test_reset();
    test_basic_frame();
    test_overflow();
    test_full_pop();
    test_short_frame();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
